dff_bank_multimode: RTL and testbench

//  Parametrised bank of WIDTH flip-flops with complementary outputs; successor to the single-bit set/reset D flop.

---
 rtl/dff_bank_multimode.sv | 105 ++++++++++
 tb/tb_dff_bank_multimode.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_multimode.sv
// WIDTH-bit register bank with complementary outputs, four update modes and
// change/stability tracking; all state moves on one selectable clock edge.
module dff_bank_multimode #(
  parameter int               WIDTH         = 8,
  parameter bit               NEGEDGE       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0,
  parameter logic [WIDTH-1:0] SET_VAL       = '1,
  parameter int               STABLE_CYCLES = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 set,
  input  logic [1:0]                           mode,
  input  logic [WIDTH-1:0]                     en,
  input  logic [WIDTH-1:0]                     d,
  input  logic                                 sin,
  output logic [WIDTH-1:0]                     q,
  output logic [WIDTH-1:0]                     qn,
  output logic                                 sout,
  output logic                                 changed,
  output logic                                 stable,
  output logic [$clog2(STABLE_CYCLES+1)-1:0]   stable_cnt
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] qn_reg, qn_next;
  logic [WIDTH-1:0] mode_next;
  logic             changed_reg, changed_next;
  logic             stable_reg, stable_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             diff;

  // Per-bit next value for the selected mode; bit 0 takes sin when shifting.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic shift_in;
    if (gi == 0) begin : g_lsb
      assign shift_in = sin;
    end else begin : g_upper
      assign shift_in = q_reg[gi-1];
    end
    assign mode_next[gi] = (mode == 2'b01) ? (en[gi] ? d[gi] : q_reg[gi]) :
                           (mode == 2'b10) ? (q_reg[gi] ^ (en[gi] & d[gi])) :
                           (mode == 2'b11) ? shift_in :
                                             q_reg[gi];
  end

  always_comb begin
    q_next       = set ? SET_VAL : mode_next;
    qn_next      = ~q_next;
    diff         = (q_next != q_reg);
    changed_next = diff;
    cnt_next     = '0;
    stable_next  = 1'b0;
    if (!diff) begin
      cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
      stable_next = (cnt_next == CNT_MAX);
    end
  end

  // Same register body on whichever edge NEGEDGE selects.
  if (NEGEDGE) begin : g_neg
    always_ff @(negedge clk) begin
      if (reset) begin
        q_reg       <= RESET_VAL;
        qn_reg      <= ~RESET_VAL;
        changed_reg <= 1'b0;
        stable_reg  <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        q_reg       <= q_next;
        qn_reg      <= qn_next;
        changed_reg <= changed_next;
        stable_reg  <= stable_next;
        cnt_reg     <= cnt_next;
      end
    end
  end else begin : g_pos
    always_ff @(posedge clk) begin
      if (reset) begin
        q_reg       <= RESET_VAL;
        qn_reg      <= ~RESET_VAL;
        changed_reg <= 1'b0;
        stable_reg  <= 1'b0;
        cnt_reg     <= '0;
      end else begin
        q_reg       <= q_next;
        qn_reg      <= qn_next;
        changed_reg <= changed_next;
        stable_reg  <= stable_next;
        cnt_reg     <= cnt_next;
      end
    end
  end

  assign q          = q_reg;
  assign qn         = qn_reg;
  assign sout       = q_reg[WIDTH-1];
  assign changed    = changed_reg;
  assign stable     = stable_reg;
  assign stable_cnt = cnt_reg;

endmodule

// File: tb/tb_dff_bank_multimode.sv
// Directed bench for dff_bank_multimode: a falling-edge bank (main) and a
// rising-edge bank (edge-select rerun) sharing one clock.
module tb_dff_bank_multimode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_reset, n_set, n_sin;
  logic [1:0] n_mode;
  logic [7:0] n_en, n_d;
  logic [7:0] n_q, n_qn;
  logic       n_sout, n_changed, n_stable;
  logic [2:0] n_cnt;

  logic       p_reset, p_set, p_sin;
  logic [1:0] p_mode;
  logic [7:0] p_en, p_d;
  logic [7:0] p_q, p_qn;
  logic       p_sout, p_changed, p_stable;
  logic [2:0] p_cnt;

  int n_vec = 0;
  int n_err = 0;

  dff_bank_multimode #(.WIDTH(8), .NEGEDGE(1'b1), .RESET_VAL(8'h00),
                       .SET_VAL(8'hFF), .STABLE_CYCLES(4)) dut_n (
    .clk(clk), .reset(n_reset), .set(n_set), .mode(n_mode), .en(n_en),
    .d(n_d), .sin(n_sin), .q(n_q), .qn(n_qn), .sout(n_sout),
    .changed(n_changed), .stable(n_stable), .stable_cnt(n_cnt));

  dff_bank_multimode #(.WIDTH(8), .NEGEDGE(1'b0), .RESET_VAL(8'h00),
                       .SET_VAL(8'hFF), .STABLE_CYCLES(4)) dut_p (
    .clk(clk), .reset(p_reset), .set(p_set), .mode(p_mode), .en(p_en),
    .d(p_d), .sin(p_sin), .q(p_q), .qn(p_qn), .sout(p_sout),
    .changed(p_changed), .stable(p_stable), .stable_cnt(p_cnt));

  task automatic tick_n;
    @(negedge clk);
    #1;
  endtask

  task automatic tick_p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_reset = 1'b1;
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=00 qn=FF ch=0 cnt=0 st=0",
               n_q, n_qn, n_changed, n_cnt, n_stable);
    end else $display("vec %0d reset q=%h qn=%h", n_vec, n_q, n_qn);
    n_reset = 1'b0;
    // A rising edge with load inputs present must leave the falling-edge bank alone.
    n_mode = 2'b01; n_en = 8'hFF; n_d = 8'h5A;
    tick_p;
    n_vec++;
    if ({n_q, n_qn, n_changed} !== {8'h00, 8'hFF, 1'b0}) begin
      n_err++;
      $display("FAIL rising_edge_ignored: got q=%h qn=%h ch=%b, want q=00 qn=FF ch=0",
               n_q, n_qn, n_changed);
    end else $display("vec %0d rising edge ignored q=%h", n_vec, n_q);
    n_mode = 2'b00;
  endtask

  task automatic test_load_and_stability;
    logic [2:0] exp_cnt;
    logic       exp_st;
    n_mode = 2'b01; n_en = 8'h0F; n_d = 8'hA5;
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h05, 8'hFA, 1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL load_masked: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=05 qn=FA ch=1 cnt=0 st=0",
               n_q, n_qn, n_changed, n_cnt, n_stable);
    end else $display("vec %0d load q=%h", n_vec, n_q);
    n_mode = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      tick_n;
      exp_cnt = (i > 4) ? 3'd4 : 3'(i);
      exp_st  = (i >= 4);
      n_vec++;
      if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h05, 8'hFA, 1'b0, exp_cnt, exp_st}) begin
        n_err++;
        $display("FAIL hold_%0d: got q=%h ch=%b cnt=%0d st=%b, want q=05 ch=0 cnt=%0d st=%b",
                 i, n_q, n_changed, n_cnt, n_stable, exp_cnt, exp_st);
      end else $display("vec %0d hold cnt=%0d st=%b", n_vec, n_cnt, n_stable);
    end
  endtask

  task automatic test_toggle;
    n_mode = 2'b10; n_en = 8'hFF; n_d = 8'h0F;
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h0A, 8'hF5, 1'b1, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL toggle_1: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=0A qn=F5 ch=1 cnt=0 st=0",
               n_q, n_qn, n_changed, n_cnt, n_stable);
    end else $display("vec %0d toggle q=%h", n_vec, n_q);
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed} !== {8'h05, 8'hFA, 1'b1}) begin
      n_err++;
      $display("FAIL toggle_2: got q=%h qn=%h ch=%b, want q=05 qn=FA ch=1",
               n_q, n_qn, n_changed);
    end else $display("vec %0d toggle q=%h", n_vec, n_q);
    n_mode = 2'b00;
  endtask

  task automatic test_shift;
    logic [7:0] exp_q;
    n_mode = 2'b01; n_en = 8'hFF; n_d = 8'h81;
    tick_n;
    n_mode = 2'b11; n_sin = 1'b1; n_en = 8'h00;
    #1;
    n_vec++;
    if (n_sout !== 1'b1) begin
      n_err++;
      $display("FAIL sout_pre_edge: got %b, want 1", n_sout);
    end else $display("vec %0d sout=%b", n_vec, n_sout);
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed} !== {8'h03, 8'hFC, 1'b1}) begin
      n_err++;
      $display("FAIL shift_in_1: got q=%h qn=%h ch=%b, want q=03 qn=FC ch=1",
               n_q, n_qn, n_changed);
    end else $display("vec %0d shift q=%h", n_vec, n_q);
    n_sin = 1'b0;
    exp_q = 8'h03;
    for (int i = 1; i <= 8; i++) begin
      tick_n;
      exp_q = {exp_q[6:0], 1'b0};
      n_vec++;
      if ({n_q, n_qn, n_sout} !== {exp_q, ~exp_q, exp_q[7]}) begin
        n_err++;
        $display("FAIL shift0_%0d: got q=%h qn=%h sout=%b, want q=%h qn=%h sout=%b",
                 i, n_q, n_qn, n_sout, exp_q, ~exp_q, exp_q[7]);
      end else $display("vec %0d shift q=%h", n_vec, n_q);
    end
    n_mode = 2'b00;
  endtask

  task automatic test_set_priority;
    n_set = 1'b1; n_reset = 1'b1;
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_over_set: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=00 qn=FF ch=0 cnt=0 st=0",
               n_q, n_qn, n_changed, n_cnt, n_stable);
    end else $display("vec %0d reset beats set q=%h", n_vec, n_q);
    n_reset = 1'b0; n_mode = 2'b01; n_en = 8'hFF; n_d = 8'h00;
    tick_n;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt} !== {8'hFF, 8'h00, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL set_over_load: got q=%h qn=%h ch=%b cnt=%0d, want q=FF qn=00 ch=1 cnt=0",
               n_q, n_qn, n_changed, n_cnt);
    end else $display("vec %0d set q=%h", n_vec, n_q);
    tick_n;
    n_vec++;
    if ({n_q, n_changed, n_cnt, n_stable} !== {8'hFF, 1'b0, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL set_unchanged: got q=%h ch=%b cnt=%0d st=%b, want q=FF ch=0 cnt=1 st=0",
               n_q, n_changed, n_cnt, n_stable);
    end else $display("vec %0d set again cnt=%0d", n_vec, n_cnt);
    n_set = 1'b0;
  endtask

  task automatic test_reset_midrun;
    // Masked-off load counts as no change.
    n_mode = 2'b01; n_en = 8'h00; n_d = 8'h00;
    tick_n;
    n_mode = 2'b00;
    tick_n;
    tick_n;
    n_vec++;
    if ({n_q, n_changed, n_cnt, n_stable} !== {8'hFF, 1'b0, 3'd4, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset_stable: got q=%h ch=%b cnt=%0d st=%b, want q=FF ch=0 cnt=4 st=1",
               n_q, n_changed, n_cnt, n_stable);
    end else $display("vec %0d stable cnt=%0d", n_vec, n_cnt);
    n_reset = 1'b1;
    tick_n;
    n_reset = 1'b0;
    n_vec++;
    if ({n_q, n_qn, n_changed, n_cnt, n_stable} !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL midrun_reset: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=00 qn=FF ch=0 cnt=0 st=0",
               n_q, n_qn, n_changed, n_cnt, n_stable);
    end else $display("vec %0d midrun reset", n_vec);
    tick_n;
    n_vec++;
    if ({n_q, n_changed, n_cnt, n_stable} !== {8'h00, 1'b0, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_hold: got q=%h ch=%b cnt=%0d st=%b, want q=00 ch=0 cnt=1 st=0",
               n_q, n_changed, n_cnt, n_stable);
    end else $display("vec %0d post reset cnt=%0d", n_vec, n_cnt);
  endtask

  task automatic test_posedge;
    logic [2:0] exp_cnt;
    logic       exp_st;
    p_reset = 1'b1;
    tick_p;
    p_reset = 1'b0;
    n_vec++;
    if ({p_q, p_qn, p_changed, p_cnt, p_stable} !== {8'h00, 8'hFF, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL pos_reset: got q=%h qn=%h ch=%b cnt=%0d st=%b, want q=00 qn=FF ch=0 cnt=0 st=0",
               p_q, p_qn, p_changed, p_cnt, p_stable);
    end else $display("vec %0d pos reset", n_vec);
    p_mode = 2'b01; p_en = 8'h0F; p_d = 8'hA5;
    tick_p;
    n_vec++;
    if ({p_q, p_qn, p_changed, p_cnt} !== {8'h05, 8'hFA, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL pos_load: got q=%h qn=%h ch=%b cnt=%0d, want q=05 qn=FA ch=1 cnt=0",
               p_q, p_qn, p_changed, p_cnt);
    end else $display("vec %0d pos load q=%h", n_vec, p_q);
    p_mode = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      tick_p;
      exp_cnt = (i > 4) ? 3'd4 : 3'(i);
      exp_st  = (i >= 4);
      n_vec++;
      if ({p_q, p_changed, p_cnt, p_stable} !== {8'h05, 1'b0, exp_cnt, exp_st}) begin
        n_err++;
        $display("FAIL pos_hold_%0d: got q=%h ch=%b cnt=%0d st=%b, want q=05 ch=0 cnt=%0d st=%b",
                 i, p_q, p_changed, p_cnt, p_stable, exp_cnt, exp_st);
      end else $display("vec %0d pos hold cnt=%0d", n_vec, p_cnt);
    end
  endtask

  initial begin
    n_reset = 1'b0; n_set = 1'b0; n_mode = 2'b00; n_en = 8'h00; n_d = 8'h00; n_sin = 1'b0;
    p_reset = 1'b1; p_set = 1'b0; p_mode = 2'b00; p_en = 8'h00; p_d = 8'h00; p_sin = 1'b0;
    #2;
    test_reset;
    test_load_and_stability;
    test_toggle;
    test_shift;
    test_set_priority;
    test_reset_midrun;
    @(negedge clk);
    #1;
    test_posedge;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
